// File: rtl/z_core_sequencer.sv
// Multi-cycle control sequencer: one-hot FETCH/DECODE/EXECUTE/MEM/WRITE/TRAP FSM
// owning pc, ir, load capture, next-PC selection and bus-timeout traps.
module z_core_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              MEM_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic [31:0]     ir,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ld_q,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_branch,
  output logic            alu_load,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic [XLEN-1:0] link_pc,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  typedef enum logic [5:0] {
    S_FETCH  = 6'b000001,
    S_DECODE = 6'b000010,
    S_EXEC   = 6'b000100,
    S_MEM    = 6'b001000,
    S_WRITE  = 6'b010000,
    S_TRAP   = 6'b100000
  } state_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] pc_old;

  logic            is_load, is_store, is_branch, is_jal, is_jalr, is_lui, legal;
  logic [XLEN-1:0] imm_b, imm_j, next_pc;
  logic            misaligned, timeout_hit;

  always_comb begin
    is_load   = (ir[6:0] == OP_LOAD);
    is_store  = (ir[6:0] == OP_STORE);
    is_branch = (ir[6:0] == OP_BRANCH);
    is_jal    = (ir[6:0] == OP_JAL);
    is_jalr   = (ir[6:0] == OP_JALR);
    is_lui    = (ir[6:0] == OP_LUI);
    legal     = is_load | is_store | is_branch | is_jal | is_jalr | is_lui |
                (ir[6:0] == OP_REG) | (ir[6:0] == OP_IMM) | (ir[6:0] == OP_AUIPC);
  end

  assign imm_b = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  always_comb begin
    next_pc = pc + XLEN'(4);
    if (is_jalr)                      next_pc = {alu_res[XLEN-1:1], 1'b0};
    else if (is_jal)                  next_pc = pc + imm_j;
    else if (is_branch && alu_branch) next_pc = pc + imm_b;
  end

  assign misaligned  = |next_pc[1:0];
  // Limit is the last waiting cycle; a mem_ready in that same cycle is checked first.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  // Strobes are decoded from the state register; reset masks them in the reset cycle.
  assign mem_req  = (state == S_FETCH) | ((state == S_MEM) & ~reset);
  assign mem_we   = (state == S_MEM) & is_store & ~reset;
  assign mem_addr = (state == S_MEM) ? addr_q : pc;
  assign alu_load = (state == S_DECODE) & legal & ~stall & ~reset;
  assign rf_we    = (state == S_WRITE) & ~stall & ~reset;
  assign trap     = (state == S_TRAP) & ~reset;
  assign link_pc  = pc_old + XLEN'(4);

  always_comb begin
    wb_sel = 2'd0;
    if (is_load)               wb_sel = 2'd1;
    else if (is_jal | is_jalr) wb_sel = 2'd2;
    else if (is_lui)           wb_sel = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= RESET_VECTOR;
      pc_old     <= RESET_VECTOR;
      ir         <= '0;
      ld_q       <= '0;
      addr_q     <= '0;
      trap_cause <= 2'd0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end else if (timeout_hit) begin
            trap_cause <= 2'd2;
            state      <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (!stall) begin
            if (!legal) begin
              trap_cause <= 2'd0;
              state      <= S_TRAP;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (!stall) begin
            pc_old <= pc;
            if (misaligned) begin
              trap_cause <= 2'd1;
              state      <= S_TRAP;
            end else begin
              pc <= next_pc;
              if (is_load | is_store) begin
                addr_q <= alu_res;
                state  <= S_MEM;
              end else if (is_branch) begin
                state <= S_FETCH;
              end else begin
                state <= S_WRITE;
              end
            end
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            if (is_load) begin
              ld_q  <= mem_rdata;
              state <= S_WRITE;
            end else begin
              state <= S_FETCH;
            end
          end else if (timeout_hit) begin
            trap_cause <= 2'd2;
            state      <= S_TRAP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_WRITE: begin
          wait_cnt <= '0;
          if (!stall) state <= S_FETCH;
        end
        S_TRAP: begin
          wait_cnt <= '0;
          pc       <= TRAP_VECTOR;
          state    <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_z_core_sequencer.sv
// Directed bench for z_core_sequencer; rf_we/trap pulses are matched against a
// queue of expected write-back/trap events.
module tb_z_core_sequencer;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset, stall, mem_ready, alu_branch;
  logic [31:0]     mem_rdata;
  logic [XLEN-1:0] alu_res;
  logic            mem_req, mem_we, alu_load, rf_we, trap;
  logic [XLEN-1:0] mem_addr, pc, link_pc;
  logic [31:0]     ir, ld_q;
  logic [1:0]      wb_sel, trap_cause;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { bit is_trap; logic [1:0] code; } ev_t;
  ev_t exp_q[$];

  localparam logic [31:0] I_ADDI  = 32'h0010_0093;
  localparam logic [31:0] I_LW    = 32'h0000_A103;
  localparam logic [31:0] I_SW    = 32'h0011_2023;
  localparam logic [31:0] I_JAL24 = 32'h0180_00EF;
  localparam logic [31:0] I_JAL8  = 32'h0080_006F;
  localparam logic [31:0] I_BEQM8 = 32'hFE00_0CE3;
  localparam logic [31:0] I_JALR  = 32'h0001_00E7;
  localparam logic [31:0] I_ILL   = 32'h0000_007F;

  z_core_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ir(ir), .pc(pc), .ld_q(ld_q),
    .alu_res(alu_res), .alu_branch(alu_branch), .alu_load(alu_load),
    .rf_we(rf_we), .wb_sel(wb_sel), .link_pc(link_pc),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input bit is_trap, input logic [1:0] code);
    ev_t e;
    e.is_trap = is_trap;
    e.code    = code;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every rf_we or trap pulse must match the next queued event.
  always @(negedge clk) begin
    if (rf_we === 1'b1 || trap === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {62'd0, rf_we, trap}, 64'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_kind", {63'd0, trap}, {63'd0, e.is_trap});
        chk("ev_single", {63'd0, rf_we & trap}, 64'd0);
        if (e.is_trap) chk("trap_cause", {62'd0, trap_cause}, {62'd0, e.code});
        else           chk("wb_sel", {62'd0, wb_sel}, {62'd0, e.code});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called in FETCH; returns in DECODE.
  task automatic do_fetch(input logic [31:0] instr, input int dly, input logic [XLEN-1:0] addr);
    for (int i = 0; i < dly; i++) begin
      chk("fetch_wait_req", {63'd0, mem_req}, 64'd1);
      cyc();
    end
    chk("fetch_addr", {32'd0, mem_addr}, {32'd0, addr});
    chk("fetch_we", {63'd0, mem_we}, 64'd0);
    mem_ready = 1'b1;
    mem_rdata = instr;
    cyc();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    chk("ir", {32'd0, ir}, {32'd0, instr});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    alu_res = '0; alu_branch = 1'b0;
    cyc(); cyc();
    chk("rst_pc", {32'd0, pc}, 64'd0);
    chk("rst_ir", {32'd0, ir}, 64'd0);
    chk("rst_ldq", {32'd0, ld_q}, 64'd0);
    chk("rst_cause", {62'd0, trap_cause}, 64'd0);
    chk("rst_strobes", {59'd0, mem_req, mem_we, alu_load, rf_we, trap}, 64'h10);
    reset = 1'b0;

    // ADDI at 0
    do_fetch(I_ADDI, 0, 32'h0);
    chk("addi_alu_load", {63'd0, alu_load}, 64'd1);
    expect_ev(1'b0, 2'd0);
    cyc();
    chk("addi_alu_load_once", {63'd0, alu_load}, 64'd0);
    cyc();
    chk("addi_pc", {32'd0, pc}, 64'h4);
    chk("addi_rf_we", {63'd0, rf_we}, 64'd1);
    cyc();

    // LW with 3 wait cycles in MEM
    do_fetch(I_LW, 0, 32'h4);
    cyc();
    alu_res = 32'h200;
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("lw_req", {62'd0, mem_req, mem_we}, 64'h2);
      chk("lw_addr", {32'd0, mem_addr}, 64'h200);
      cyc();
    end
    chk("lw_addr_last", {32'd0, mem_addr}, 64'h200);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_BABE;
    expect_ev(1'b0, 2'd1);
    cyc();
    mem_ready = 1'b0; mem_rdata = 32'h0;
    chk("lw_ldq", {32'd0, ld_q}, 64'hCAFE_BABE);
    chk("lw_pc", {32'd0, pc}, 64'h8);
    cyc();

    // JAL x1,+24 from 8
    do_fetch(I_JAL24, 0, 32'h8);
    expect_ev(1'b0, 2'd2);
    cyc(); cyc();
    chk("jal_pc", {32'd0, pc}, 64'h20);
    chk("jal_link", {32'd0, link_pc}, 64'hC);
    cyc();

    // BEQ -8 at 0x20, taken
    do_fetch(I_BEQM8, 0, 32'h20);
    alu_branch = 1'b1;
    cyc(); cyc();
    alu_branch = 1'b0;
    chk("beq_taken_pc", {32'd0, pc}, 64'h18);
    do_fetch(I_JAL8, 0, 32'h18);
    expect_ev(1'b0, 2'd2);
    cyc(); cyc();
    chk("jal8_pc", {32'd0, pc}, 64'h20);
    cyc();
    // BEQ at 0x20, not taken
    do_fetch(I_BEQM8, 0, 32'h20);
    cyc(); cyc();
    chk("beq_fall_pc", {32'd0, pc}, 64'h24);

    // JALR to misaligned target
    do_fetch(I_JALR, 0, 32'h24);
    expect_ev(1'b1, 2'd1);
    cyc();
    alu_res = 32'h1002;
    cyc();
    chk("jalr_mis_pc_held", {32'd0, pc}, 64'h24);
    chk("jalr_mis_trap", {62'd0, trap, mem_req}, 64'h2);
    cyc();
    chk("trap_vec_pc", {32'd0, pc}, 64'h100);
    // JALR with bit0 set is cleared, not trapped
    do_fetch(I_JALR, 0, 32'h100);
    expect_ev(1'b0, 2'd2);
    cyc();
    alu_res = 32'h1001;
    cyc();
    chk("jalr_pc", {32'd0, pc}, 64'h1000);
    chk("jalr_link", {32'd0, link_pc}, 64'h104);
    cyc();

    // Illegal opcode
    do_fetch(I_ILL, 0, 32'h1000);
    chk("ill_no_alu_load", {63'd0, alu_load}, 64'd0);
    expect_ev(1'b1, 2'd0);
    cyc();
    chk("ill_cause", {62'd0, trap_cause}, 64'd0);
    cyc();
    chk("ill_pc", {32'd0, pc}, 64'h100);

    // Fetch timeout after 16 cycles without mem_ready
    expect_ev(1'b1, 2'd2);
    for (int i = 0; i < 16; i++) begin
      chk("to_req", {63'd0, mem_req}, 64'd1);
      cyc();
    end
    chk("to_trap", {63'd0, trap}, 64'd1);
    cyc();
    chk("to_pc", {32'd0, pc}, 64'h100);

    // mem_ready on cycle 16 wins over the limit; then stall in EXECUTE and WRITE
    do_fetch(I_ADDI, 15, 32'h100);
    chk("limit_ready_wins", {63'd0, alu_load}, 64'd1);
    expect_ev(1'b0, 2'd0);
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc", {32'd0, pc}, 64'h100);
      chk("stall_alu_load", {63'd0, alu_load}, 64'd0);
      cyc();
    end
    stall = 1'b0;
    cyc();
    chk("post_stall_pc", {32'd0, pc}, 64'h104);
    stall = 1'b1;
    cyc();
    chk("stall_wr_rf_we", {63'd0, rf_we}, 64'd0);
    stall = 1'b0;
    cyc();
    chk("post_wr_addr", {32'd0, mem_addr}, 64'h104);

    // SW, one wait cycle
    do_fetch(I_SW, 0, 32'h104);
    cyc();
    alu_res = 32'h300;
    cyc();
    chk("sw_we", {62'd0, mem_req, mem_we}, 64'h3);
    chk("sw_addr", {32'd0, mem_addr}, 64'h300);
    cyc();
    chk("sw_we_held", {63'd0, mem_we}, 64'd1);
    mem_ready = 1'b1;
    cyc();
    mem_ready = 1'b0;
    chk("sw_done", {31'd0, mem_we, pc}, 64'h108);

    // Reset during a load's MEM wait
    do_fetch(I_LW, 0, 32'h108);
    cyc();
    alu_res = 32'h400;
    cyc(); cyc(); cyc();
    chk("mem_wait_addr", {32'd0, mem_addr}, 64'h400);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_pc", {32'd0, pc}, 64'h0);
    chk("rst_mid_bus", {62'd0, mem_req, mem_we}, 64'h2);
    chk("rst_mid_addr", {32'd0, mem_addr}, 64'h0);
    cyc(); cyc();

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
